// File: rtl/cnn_layer_sequencer.sv
// Layer sequencer for a CNN accelerator: holds per-layer descriptors, launches
// the conv/FC controller once per layer and tracks completion until the last
// layer of the run retires. The output-channel field is exposed as do_ch since
// "do" is a reserved word.
module cnn_layer_sequencer #(
    parameter int MAX_LAYERS = 8,
    parameter int LIDW       = 3,
    parameter int ADDRW      = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [LIDW-1:0]  cfg_layer,
    input  logic [3:0]       cfg_field,
    input  logic [ADDRW-1:0] cfg_data,
    input  logic [LIDW:0]    num_layers,
    input  logic             cnn_start,
    input  logic             cnn_abort,
    input  logic             pic_finish,
    input  logic             mp_finish,
    output logic             start,
    output logic [LIDW-1:0]  layer_idx,
    output logic [ADDRW-1:0] do_ch,
    output logic [ADDRW-1:0] di,
    output logic [ADDRW-1:0] dr,
    output logic [ADDRW-1:0] dc,
    output logic [ADDRW-1:0] dkr,
    output logic [ADDRW-1:0] dkc,
    output logic [ADDRW-1:0] inaddr,
    output logic [ADDRW-1:0] waddr,
    output logic [ADDRW-1:0] outaddr,
    output logic [ADDRW-1:0] mp_outaddr,
    output logic [ADDRW-1:0] dr_out,
    output logic [ADDRW-1:0] dc_out,
    output logic [ADDRW-1:0] mp_dr_out,
    output logic [ADDRW-1:0] mp_dc_out,
    output logic [2:0]       step,
    output logic             relu,
    output logic             maxpool_en,
    output logic             busy,
    output logic             cnn_finish,
    output logic             aborted,
    output logic             cfg_err
);

    typedef enum logic [2:0] {
        StIdle,
        StLaunch1,
        StLaunch2,
        StRun,
        StAdvance
    } state_t;

    state_t            state_q, state_d;
    logic [LIDW-1:0]   layer_q, layer_d;
    logic [LIDW:0]     count_q, count_d;
    logic              cnn_start_q;
    logic              pic_q;
    logic              mp_q;

    // Descriptor storage; deliberately not reset so programming survives rst.
    logic [ADDRW-1:0]  do_mem     [MAX_LAYERS];
    logic [ADDRW-1:0]  di_mem     [MAX_LAYERS];
    logic [ADDRW-1:0]  dr_mem     [MAX_LAYERS];
    logic [ADDRW-1:0]  dc_mem     [MAX_LAYERS];
    logic [ADDRW-1:0]  dkr_mem    [MAX_LAYERS];
    logic [ADDRW-1:0]  dkc_mem    [MAX_LAYERS];
    logic [ADDRW-1:0]  in_mem     [MAX_LAYERS];
    logic [ADDRW-1:0]  w_mem      [MAX_LAYERS];
    logic [ADDRW-1:0]  out_mem    [MAX_LAYERS];
    logic [ADDRW-1:0]  mpout_mem  [MAX_LAYERS];
    logic [2:0]        flags_mem  [MAX_LAYERS];

    logic              start_edge;
    logic              num_ok;
    logic              wr_ok;
    logic              launch_err;
    logic              layer_done;
    logic              is_last;
    logic              step2;
    logic [ADDRW-1:0]  r_diff;
    logic [ADDRW-1:0]  c_diff;

    assign start_edge = cnn_start & ~cnn_start_q;
    assign num_ok     = (num_layers != '0) && (32'(num_layers) <= 32'(MAX_LAYERS));
    assign wr_ok      = rst && cfg_we && (state_q == StIdle) &&
                        (32'(cfg_layer) < 32'(MAX_LAYERS)) && (cfg_field <= 4'd10);
    assign is_last    = (32'(layer_q) + 32'd1) == 32'(count_q);
    // Max-pool layers retire on the pool engine's edge, others on the conv edge.
    assign layer_done = maxpool_en ? (mp_q & ~mp_finish) : (pic_q & ~pic_finish);
    assign busy       = (state_q != StIdle);
    assign layer_idx  = layer_q;
    assign cfg_err    = rst & ((cfg_we & ~wr_ok) | launch_err);

    // State, layer index, latched count and input edge registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            layer_q     <= '0;
            count_q     <= '0;
            cnn_start_q <= 1'b0;
            pic_q       <= 1'b0;
            mp_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            layer_q     <= layer_d;
            count_q     <= count_d;
            cnn_start_q <= cnn_start;
            pic_q       <= pic_finish;
            mp_q        <= mp_finish;
        end
    end

    // Next-state logic and the start/finish/abort pulses.
    always_comb begin
        state_d    = state_q;
        layer_d    = layer_q;
        count_d    = count_q;
        start      = 1'b0;
        cnn_finish = 1'b0;
        aborted    = 1'b0;
        launch_err = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_edge) begin
                    if (num_ok) begin
                        count_d = num_layers;
                        layer_d = '0;
                        state_d = StLaunch1;
                    end else begin
                        launch_err = 1'b1;
                    end
                end
            end
            StLaunch1: begin
                if (cnn_abort) begin
                    aborted = 1'b1;
                    state_d = StIdle;
                end else begin
                    state_d = StLaunch2;
                end
            end
            StLaunch2, StAdvance: begin
                if (cnn_abort) begin
                    aborted = 1'b1;
                    state_d = StIdle;
                end else begin
                    start   = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                // Abort takes priority over a coincident completion edge.
                if (cnn_abort) begin
                    aborted = 1'b1;
                    state_d = StIdle;
                end else if (layer_done) begin
                    if (is_last) begin
                        cnn_finish = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        layer_d = layer_q + LIDW'(1);
                        state_d = StAdvance;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (state_d == StIdle) begin
            layer_d = '0;
        end
    end

    // Descriptor writes, accepted only in IDLE for an existing slot and field.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            case (cfg_field)
                4'd0:    do_mem[cfg_layer]    <= cfg_data;
                4'd1:    di_mem[cfg_layer]    <= cfg_data;
                4'd2:    dr_mem[cfg_layer]    <= cfg_data;
                4'd3:    dc_mem[cfg_layer]    <= cfg_data;
                4'd4:    dkr_mem[cfg_layer]   <= cfg_data;
                4'd5:    dkc_mem[cfg_layer]   <= cfg_data;
                4'd6:    in_mem[cfg_layer]    <= cfg_data;
                4'd7:    w_mem[cfg_layer]     <= cfg_data;
                4'd8:    out_mem[cfg_layer]   <= cfg_data;
                4'd9:    mpout_mem[cfg_layer] <= cfg_data;
                4'd10:   flags_mem[cfg_layer] <= cfg_data[2:0];
                default: ;
            endcase
        end
    end

    // Active descriptor readout; IDLE presents zeros with ReLU defaulting on.
    always_comb begin
        do_ch      = '0;
        di         = '0;
        dr         = '0;
        dc         = '0;
        dkr        = '0;
        dkc        = '0;
        inaddr     = '0;
        waddr      = '0;
        outaddr    = '0;
        mp_outaddr = '0;
        relu       = 1'b1;
        maxpool_en = 1'b0;
        step2      = 1'b0;
        step       = 3'd0;
        if (busy) begin
            do_ch      = do_mem[layer_q];
            di         = di_mem[layer_q];
            dr         = dr_mem[layer_q];
            dc         = dc_mem[layer_q];
            dkr        = dkr_mem[layer_q];
            dkc        = dkc_mem[layer_q];
            inaddr     = in_mem[layer_q];
            waddr      = w_mem[layer_q];
            outaddr    = out_mem[layer_q];
            mp_outaddr = mpout_mem[layer_q];
            relu       = flags_mem[layer_q][0];
            maxpool_en = flags_mem[layer_q][1];
            step2      = flags_mem[layer_q][2];
            step       = step2 ? 3'd2 : 3'd1;
        end
    end

    // Derived output dimensions; zero in IDLE, pool dims zero without max-pool.
    always_comb begin
        r_diff    = dr - dkr;
        c_diff    = dc - dkc;
        dr_out    = '0;
        dc_out    = '0;
        mp_dr_out = '0;
        mp_dc_out = '0;
        if (busy) begin
            dr_out = (step2 ? (r_diff >> 1) : r_diff) + ADDRW'(1);
            dc_out = (step2 ? (c_diff >> 1) : c_diff) + ADDRW'(1);
            if (maxpool_en) begin
                mp_dr_out = dr_out >> 1;
                mp_dc_out = dc_out >> 1;
            end
        end
    end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Directed bench for cnn_layer_sequencer: programs a small CIFAR-style network,
// runs it and exercises the error, abort and reset paths.
module tb_cnn_layer_sequencer;

    localparam int MAX_LAYERS = 8;
    localparam int LIDW       = 3;
    localparam int ADDRW      = 20;

    logic             clk;
    logic             rst;
    logic             cfg_we;
    logic [LIDW-1:0]  cfg_layer;
    logic [3:0]       cfg_field;
    logic [ADDRW-1:0] cfg_data;
    logic [LIDW:0]    num_layers;
    logic             cnn_start;
    logic             cnn_abort;
    logic             pic_finish;
    logic             mp_finish;
    logic             start;
    logic [LIDW-1:0]  layer_idx;
    logic [ADDRW-1:0] do_ch, di, dr, dc, dkr, dkc, inaddr, waddr, outaddr, mp_outaddr;
    logic [ADDRW-1:0] dr_out, dc_out, mp_dr_out, mp_dc_out;
    logic [2:0]       step;
    logic             relu, maxpool_en, busy, cnn_finish, aborted, cfg_err;

    int n_cmp  = 0;
    int n_fail = 0;
    int start_cnt  = 0;
    int finish_cnt = 0;

    cnn_layer_sequencer #(
        .MAX_LAYERS (MAX_LAYERS),
        .LIDW       (LIDW),
        .ADDRW      (ADDRW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_layer  (cfg_layer),
        .cfg_field  (cfg_field),
        .cfg_data   (cfg_data),
        .num_layers (num_layers),
        .cnn_start  (cnn_start),
        .cnn_abort  (cnn_abort),
        .pic_finish (pic_finish),
        .mp_finish  (mp_finish),
        .start      (start),
        .layer_idx  (layer_idx),
        .do_ch      (do_ch),
        .di         (di),
        .dr         (dr),
        .dc         (dc),
        .dkr        (dkr),
        .dkc        (dkc),
        .inaddr     (inaddr),
        .waddr      (waddr),
        .outaddr    (outaddr),
        .mp_outaddr (mp_outaddr),
        .dr_out     (dr_out),
        .dc_out     (dc_out),
        .mp_dr_out  (mp_dr_out),
        .mp_dc_out  (mp_dc_out),
        .step       (step),
        .relu       (relu),
        .maxpool_en (maxpool_en),
        .busy       (busy),
        .cnn_finish (cnn_finish),
        .aborted    (aborted),
        .cfg_err    (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters, sampled at the active edge while inputs are stable.
    always @(posedge clk) begin
        if (start) start_cnt++;
        if (cnn_finish) finish_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cfg_write(input int layer, input int field, input int data);
        @(negedge clk);
        cfg_we    = 1'b1;
        cfg_layer = LIDW'(layer);
        cfg_field = 4'(field);
        cfg_data  = ADDRW'(data);
        @(negedge clk);
        cfg_we    = 1'b0;
    endtask

    // Program one layer: dr=dc, dkr=dkc, do, outaddr and flags.
    task automatic prog_layer(input int layer, input int dim, input int k, input int dout,
                              input int oaddr, input int flags);
        cfg_write(layer, 0, dout);
        cfg_write(layer, 2, dim);
        cfg_write(layer, 3, dim);
        cfg_write(layer, 4, k);
        cfg_write(layer, 5, k);
        cfg_write(layer, 8, oaddr);
        cfg_write(layer, 10, flags);
    endtask

    // Raise cnn_start for one cycle; returns at the negedge after the edge cycle.
    task automatic kick(input int n, input logic exp_err);
        @(negedge clk);
        num_layers = (LIDW+1)'(n);
        cnn_start  = 1'b1;
        #1 check_eq("launch_cfg_err", 32'(cfg_err), 32'(exp_err));
        @(negedge clk);
        cnn_start = 1'b0;
    endtask

    // Wait (bounded) for start; leaves the bench at the negedge where start is high.
    task automatic wait_start(input string tag);
        int k;
        k = 0;
        while (!start && k < 20) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, 32'(start), 32'd1);
    endtask

    // Falling edge on pic_finish or mp_finish; checks the completion outcome.
    task automatic finish_layer(input logic use_mp, input logic last, input int next_idx);
        @(negedge clk);
        if (use_mp) mp_finish = 1'b1; else pic_finish = 1'b1;
        @(negedge clk);
        mp_finish  = 1'b0;
        pic_finish = 1'b0;
        #1 check_eq("finish_pulse", 32'(cnn_finish), 32'(last));
        @(negedge clk);
        if (last) begin
            check_eq("idle_after_last", 32'(busy), 32'd0);
        end else begin
            check_eq("advance_start", 32'(start), 32'd1);
            check_eq("advance_idx", 32'(layer_idx), 32'(next_idx));
        end
    endtask

    initial begin
        rst = 1'b0;
        cfg_we = 1'b0; cfg_layer = '0; cfg_field = '0; cfg_data = '0;
        num_layers = '0; cnn_start = 1'b0; cnn_abort = 1'b0;
        pic_finish = 1'b0; mp_finish = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_idx", 32'(layer_idx), 32'd0);
        check_eq("rst_start", 32'(start), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("idle_relu", 32'(relu), 32'd1);
        check_eq("idle_dr_out", 32'(dr_out), 32'd0);
        check_eq("idle_do", 32'(do_ch), 32'd0);

        // CIFAR-style network: 3 conv (pool on 0,1), 2 FC (no ReLU on the last).
        prog_layer(0, 32, 3, 32, 'h2000, 3);   // relu+pool, step 1
        prog_layer(1, 15, 3, 64, 'h2100, 7);   // relu+pool, step 2
        prog_layer(2, 7, 3, 64, 'h2200, 1);    // relu
        prog_layer(3, 1, 1, 128, 'h2300, 1);   // FC relu
        prog_layer(4, 1, 1, 10, 'h2400, 0);    // FC, no relu

        // Bad writes in IDLE.
        @(negedge clk);
        cfg_we = 1'b1; cfg_layer = 3'd0; cfg_field = 4'd11; cfg_data = 20'd5;
        #1 check_eq("bad_field_err", 32'(cfg_err), 32'd1);
        @(negedge clk);
        cfg_field = 4'd2;
        #1 check_eq("good_write_err", 32'(cfg_err), 32'd0);
        cfg_we = 1'b0;

        // Rejected launches.
        kick(0, 1'b1);
        check_eq("n0_busy", 32'(busy), 32'd0);
        kick(9, 1'b1);
        check_eq("n9_busy", 32'(busy), 32'd0);

        // Full five-layer run.
        start_cnt = 0;
        finish_cnt = 0;
        kick(5, 1'b0);
        check_eq("launch1_busy", 32'(busy), 32'd1);
        check_eq("launch1_nostart", 32'(start), 32'd0);
        @(negedge clk);
        check_eq("launch2_start", 32'(start), 32'd1);
        check_eq("l0_idx", 32'(layer_idx), 32'd0);
        check_eq("l0_dr_out", 32'(dr_out), 32'd30);
        check_eq("l0_mp_dr_out", 32'(mp_dr_out), 32'd15);
        check_eq("l0_dc_out", 32'(dc_out), 32'd30);
        check_eq("l0_step", 32'(step), 32'd1);
        check_eq("l0_outaddr", 32'(outaddr), 32'h2000);

        // Conv edge alone must not retire a pooling layer.
        @(negedge clk); pic_finish = 1'b1;
        @(negedge clk); pic_finish = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("l0_pic_only_idx", 32'(layer_idx), 32'd0);
        check_eq("l0_pic_only_busy", 32'(busy), 32'd1);
        finish_layer(1'b1, 1'b0, 1);
        check_eq("l1_dr_out", 32'(dr_out), 32'd7);
        check_eq("l1_step", 32'(step), 32'd2);
        check_eq("l1_mp_dc_out", 32'(mp_dc_out), 32'd3);
        check_eq("l1_do", 32'(do_ch), 32'd64);
        finish_layer(1'b1, 1'b0, 2);
        check_eq("l2_dr_out", 32'(dr_out), 32'd5);
        check_eq("l2_mp_dr_out", 32'(mp_dr_out), 32'd0);

        // Write while running is refused and leaves the descriptor alone.
        @(negedge clk);
        cfg_we = 1'b1; cfg_layer = 3'd2; cfg_field = 4'd2; cfg_data = 20'd99;
        #1 check_eq("run_write_err", 32'(cfg_err), 32'd1);
        @(negedge clk);
        cfg_we = 1'b0;
        #1 check_eq("run_write_dr", 32'(dr), 32'd7);
        finish_layer(1'b0, 1'b0, 3);
        check_eq("l3_relu", 32'(relu), 32'd1);
        finish_layer(1'b0, 1'b0, 4);
        check_eq("l4_relu", 32'(relu), 32'd0);
        check_eq("l4_dr_out", 32'(dr_out), 32'd1);
        finish_layer(1'b0, 1'b1, 0);
        check_eq("run_start_cnt", 32'(start_cnt), 32'd5);
        check_eq("run_finish_cnt", 32'(finish_cnt), 32'd1);

        // Abort coincident with the final completion edge.
        finish_cnt = 0;
        kick(1, 1'b0);
        wait_start("abort_run_start");
        @(negedge clk); mp_finish = 1'b1;
        @(negedge clk); mp_finish = 1'b0; cnn_abort = 1'b1;
        #1 check_eq("abort_pulse", 32'(aborted), 32'd1);
        check_eq("abort_no_finish", 32'(cnn_finish), 32'd0);
        @(negedge clk); cnn_abort = 1'b0;
        check_eq("abort_idle", 32'(busy), 32'd0);
        check_eq("abort_pulse_gone", 32'(aborted), 32'd0);
        check_eq("abort_finish_cnt", 32'(finish_cnt), 32'd0);

        // Reset mid-run: back to IDLE silently, descriptors retained.
        kick(2, 1'b0);
        wait_start("rst_run_start");
        @(negedge clk); rst = 1'b0;
        #1 check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_aborted", 32'(aborted), 32'd0);
        check_eq("midrst_finish", 32'(cnn_finish), 32'd0);
        check_eq("midrst_idx", 32'(layer_idx), 32'd0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        check_eq("postrst_busy", 32'(busy), 32'd0);
        check_eq("postrst_finish_cnt", 32'(finish_cnt), 32'd0);
        kick(1, 1'b0);
        wait_start("retain_start");
        check_eq("retain_dr_out", 32'(dr_out), 32'd30);
        check_eq("retain_do", 32'(do_ch), 32'd32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
